// File: rtl/tile_pkg.sv
// Shared screen geometry, tile indices and event record for the tile plot decoder.
package tile_pkg;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [7:0] SCREEN_H = 8'd120;
  localparam logic [7:0] HALF_W   = 8'd80;
  localparam logic [7:0] HALF_H   = 8'd60;

  localparam logic [1:0] TILE_TL = 2'd0;
  localparam logic [1:0] TILE_TR = 2'd1;
  localparam logic [1:0] TILE_BL = 2'd2;
  localparam logic [1:0] TILE_BR = 2'd3;

  typedef struct packed {
    logic [1:0] tile;
    logic [2:0] colour;
    logic       lit;
  } tile_event_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_t;

  function automatic logic [1:0] tile_of(input logic [7:0] px, input logic [7:0] py);
    logic right;
    logic bottom;
    right  = (px >= HALF_W);
    bottom = (py >= HALF_H);
    unique case ({bottom, right})
      2'b00:   tile_of = TILE_TL;
      2'b01:   tile_of = TILE_TR;
      2'b10:   tile_of = TILE_BL;
      default: tile_of = TILE_BR;
    endcase
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Small valid/ready event queue; head is read straight from registered storage.
module event_fifo
  import tile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  tile_event_t data_i,
  input  logic        pop_i,
  output tile_event_t head_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  tile_event_t      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the same cycle, so a full queue still accepts.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/tile_plot_decoder.sv
// Passive pixel-bus observer: rebuilds whole-tile fills from the plot stream
// and queues one {tile, colour, lit} event per completed SIDE*SIDE run.
module tile_plot_decoder
  import tile_pkg::*;
#(
  parameter int unsigned SIDE  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] colour,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_tile,
  output logic [2:0] ev_colour,
  output logic       ev_lit,
  output logic       overflow,
  output logic [7:0] abort_count,
  input  logic       clear_stats
);

  localparam int unsigned FILL  = SIDE * SIDE;
  localparam int unsigned CNT_W = $clog2(FILL) + 1;
  localparam logic [CNT_W-1:0] FILL_CNT = CNT_W'(FILL);

  logic             in_valid_q;
  logic [1:0]       in_tile_q;
  logic [2:0]       in_colour_q;

  run_state_t       state_q, state_d;
  logic [1:0]       run_tile_q, run_tile_d;
  logic [2:0]       run_colour_q, run_colour_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  logic             extend;
  logic             abort;
  logic             push;
  logic             drop;
  tile_event_t      push_ev;
  tile_event_t      head;
  logic             fifo_empty;
  logic             fifo_full;

  logic             overflow_q;
  logic [7:0]       abort_cnt_q;

  // Off-screen pixels are squashed here so they never reach the tracker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_valid_q  <= 1'b0;
      in_tile_q   <= '0;
      in_colour_q <= '0;
    end else begin
      in_valid_q  <= plot && (x < SCREEN_W) && (y < SCREEN_H);
      in_tile_q   <= tile_of(x, y);
      in_colour_q <= colour;
    end
  end

  assign extend = in_valid_q && (state_q == ST_RUN) &&
                  (in_tile_q == run_tile_q) && (in_colour_q == run_colour_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      run_tile_q   <= '0;
      run_colour_q <= '0;
      run_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      run_tile_q   <= run_tile_d;
      run_colour_q <= run_colour_d;
      run_cnt_q    <= run_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    run_tile_d   = run_tile_q;
    run_colour_d = run_colour_q;
    run_cnt_d    = run_cnt_q;
    if (in_valid_q) begin
      if (extend) begin
        run_cnt_d = run_cnt_q + CNT_W'(1);
      end else begin
        run_cnt_d    = CNT_W'(1);
        run_tile_d   = in_tile_q;
        run_colour_d = in_colour_q;
      end
      state_d = (run_cnt_d == FILL_CNT) ? ST_IDLE : ST_RUN;
    end
  end

  // Completion is the only way a valid pixel leaves the tracker in IDLE.
  always_comb begin
    abort   = 1'b0;
    push    = 1'b0;
    push_ev = '0;
    if (in_valid_q) begin
      abort = (state_q == ST_RUN) && !extend;
      push  = (state_d == ST_IDLE);
    end
    push_ev.tile   = run_tile_d;
    push_ev.colour = run_colour_d;
    push_ev.lit    = (run_colour_d != '0);
  end

  event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_ev),
    .pop_i   (ev_ready),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign drop = push && fifo_full && !(ev_ready && !fifo_empty);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      abort_cnt_q <= '0;
    end else if (clear_stats) begin
      overflow_q  <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (abort && (abort_cnt_q != '1)) abort_cnt_q <= abort_cnt_q + 8'd1;
    end
  end

  assign ev_valid    = !fifo_empty;
  assign ev_tile     = head.tile;
  assign ev_colour   = head.colour;
  assign ev_lit      = head.lit;
  assign overflow    = overflow_q;
  assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_tile_plot_decoder.sv
// Scenario bench for tile_plot_decoder with a pixel-level reference model.
module tb_tile_plot_decoder;

  localparam int SIDE  = 16;
  localparam int DEPTH = 4;
  localparam int FILL  = SIDE * SIDE;

  logic       clock = 1'b0;
  logic       reset;
  logic       plot;
  logic [7:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_tile;
  logic [2:0] ev_colour;
  logic       ev_lit;
  logic       overflow;
  logic [7:0] abort_count;
  logic       clear_stats;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  tile_plot_decoder #(
    .SIDE  (SIDE),
    .DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_tile     (ev_tile),
    .ev_colour   (ev_colour),
    .ev_lit      (ev_lit),
    .overflow    (overflow),
    .abort_count (abort_count),
    .clear_stats (clear_stats)
  );

  // Reference model: events encoded as tile*16 + colour*2 + lit.
  int m_q[$];
  int m_key   = -1;
  int m_len   = 0;
  int m_abort = 0;
  bit m_ovf   = 0;
  bit po_v = 0, pn_v = 0;
  int po_x, po_y, po_c, pn_x, pn_y, pn_c;
  bit rdy_last = 0, clr_last = 0;

  function automatic int enc(input int t, input int c);
    return t * 16 + c * 2 + ((c != 0) ? 1 : 0);
  endfunction

  // Effects of one clock edge: pop, pixel from two drives ago, then clear.
  task automatic model_edge();
    int t;
    int key;
    if (rdy_last && m_q.size() > 0) void'(m_q.pop_front());
    if (po_v && po_x < 160 && po_y < 120) begin
      t   = ((po_x >= 80) ? 1 : 0) + ((po_y >= 60) ? 2 : 0);
      key = t * 8 + po_c;
      if (key == m_key) m_len++;
      else begin
        if (m_key >= 0 && m_abort < 255) m_abort++;
        m_key = key;
        m_len = 1;
      end
      if (m_len == FILL) begin
        if (m_q.size() < DEPTH) m_q.push_back(enc(t, po_c));
        else m_ovf = 1;
        m_key = -1;
        m_len = 0;
      end
    end
    if (clr_last) begin
      m_abort = 0;
      m_ovf   = 0;
    end
    po_v = pn_v; po_x = pn_x; po_y = pn_y; po_c = pn_c;
  endtask

  task automatic tick(input bit p, input int px, input int py, input int c,
                      input bit rdy, input bit clr);
    @(posedge clock);
    #1;
    model_edge();
    plot = p; x = 8'(px); y = 8'(py); colour = 3'(c);
    ev_ready = rdy; clear_stats = clr;
    pn_v = p; pn_x = px; pn_y = py; pn_c = c;
    rdy_last = rdy; clr_last = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pop_one();
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int tile, input int c, input int n, input bit rdy,
                      input int gap_pct, input int oor_pct);
    int done = 0;
    while (done < n) begin
      if (int'($urandom_range(99)) < gap_pct)
        tick(0, int'($urandom_range(159)), int'($urandom_range(119)), int'($urandom_range(7)), rdy, 0);
      else if (int'($urandom_range(99)) < oor_pct)
        tick(1, 200, int'($urandom_range(119)), int'($urandom_range(7)), rdy, 0);
      else begin
        tick(1, (tile % 2) * 80 + int'($urandom_range(79)),
             (tile / 2) * 60 + int'($urandom_range(59)), c, rdy, 0);
        done++;
      end
    end
  endtask

  task automatic reset_on();
    @(posedge clock);
    #1;
    reset = 1; plot = 0; ev_ready = 0; clear_stats = 0; x = 0; y = 0; colour = 0;
    m_q.delete(); m_key = -1; m_len = 0; m_abort = 0; m_ovf = 0;
    po_v = 0; pn_v = 0; rdy_last = 0; clr_last = 0;
    #2;
  endtask

  task automatic reset_off();
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    reset_on();
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", ev_valid); end
    n_vec++; if (ev_tile !== 2'd0) begin n_err++; $display("FAIL reset_tile: got %0d want 0", ev_tile); end
    n_vec++; if (ev_colour !== 3'd0) begin n_err++; $display("FAIL reset_colour: got %0d want 0", ev_colour); end
    n_vec++; if (ev_lit !== 1'b0) begin n_err++; $display("FAIL reset_lit: got %0b want 0", ev_lit); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    n_vec++; if (abort_count !== 8'd0) begin n_err++; $display("FAIL reset_abort: got %0d want 0", abort_count); end
    reset_off();
  endtask

  task automatic test_single_fill();
    for (int yy = 10; yy < 26; yy++)
      for (int xx = 10; xx < 26; xx++) tick(1, xx, yy, 4, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %0b want 0", ev_valid); end
    tick(0, 0, 0, 0, 0, 0);
    n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b want 1", ev_valid); end
    n_vec++; if (ev_tile !== 2'd0) begin n_err++; $display("FAIL single_tile: got %0d want 0", ev_tile); end
    n_vec++; if (ev_colour !== 3'd4) begin n_err++; $display("FAIL single_colour: got %0d want 4", ev_colour); end
    n_vec++; if (ev_lit !== 1'b1) begin n_err++; $display("FAIL single_lit: got %0b want 1", ev_lit); end
    n_vec++; if (abort_count !== 8'd0) begin n_err++; $display("FAIL single_abort: got %0d want 0", abort_count); end
    pop_one();
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL single_drained: got %0b want 0", ev_valid); end
  endtask

  task automatic test_abort();
    fill(1, 2, 100, 0, 10, 0);
    fill(1, 0, FILL, 0, 10, 0);
    idle(2);
    n_vec++; if (abort_count !== 8'd1) begin n_err++; $display("FAIL abort_count: got %0d want 1", abort_count); end
    n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL abort_valid: got %0b want 1", ev_valid); end
    n_vec++; if (ev_tile !== 2'd1) begin n_err++; $display("FAIL abort_tile: got %0d want 1", ev_tile); end
    n_vec++; if (ev_colour !== 3'd0) begin n_err++; $display("FAIL abort_colour: got %0d want 0", ev_colour); end
    n_vec++; if (ev_lit !== 1'b0) begin n_err++; $display("FAIL abort_lit: got %0b want 0", ev_lit); end
    pop_one();
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL abort_single_event: got %0b want 0", ev_valid); end
  endtask

  task automatic test_overflow();
    int tiles[5] = '{3, 2, 1, 0, 3};
    for (int i = 0; i < 5; i++) fill(tiles[i], 7, FILL, 0, 10, 0);
    idle(2);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid[%0d]: got %0b want 1", i, ev_valid); end
      n_vec++; if (ev_tile !== 2'(tiles[i])) begin n_err++; $display("FAIL ovf_tile[%0d]: got %0d want %0d", i, ev_tile, tiles[i]); end
      n_vec++; if (ev_colour !== 3'd7) begin n_err++; $display("FAIL ovf_colour[%0d]: got %0d want 7", i, ev_colour); end
      pop_one();
    end
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %0b want 0", ev_valid); end
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    int tiles[5] = '{0, 1, 2, 3, 0};
    int cols[5]  = '{1, 2, 3, 5, 6};
    for (int i = 0; i < 5; i++) fill(tiles[i], cols[i], FILL, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow: got %0b want 0", overflow); end
    for (int i = 1; i < 5; i++) begin
      n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL fpp_valid[%0d]: got %0b want 1", i, ev_valid); end
      n_vec++; if (ev_tile !== 2'(tiles[i])) begin n_err++; $display("FAIL fpp_tile[%0d]: got %0d want %0d", i, ev_tile, tiles[i]); end
      n_vec++; if (ev_colour !== 3'(cols[i])) begin n_err++; $display("FAIL fpp_colour[%0d]: got %0d want %0d", i, ev_colour, cols[i]); end
      pop_one();
    end
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL fpp_count: got %0b want 0", ev_valid); end
  endtask

  task automatic test_out_of_range();
    int c = int'($urandom_range(7, 1));
    fill(2, c, FILL, 0, 20, 20);
    idle(2);
    n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL oor_valid: got %0b want 1", ev_valid); end
    n_vec++; if (ev_tile !== 2'd2) begin n_err++; $display("FAIL oor_tile: got %0d want 2", ev_tile); end
    n_vec++; if (ev_colour !== 3'(c)) begin n_err++; $display("FAIL oor_colour: got %0d want %0d", ev_colour, c); end
    n_vec++; if (abort_count !== 8'd0) begin n_err++; $display("FAIL oor_abort: got %0d want 0", abort_count); end
    pop_one();
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL oor_single: got %0b want 0", ev_valid); end
  endtask

  task automatic test_abort_saturate();
    for (int i = 0; i < 300; i++) tick(1, 90 + (i % 8), 70, 1 + (i % 2), 0, 0);
    idle(2);
    n_vec++; if (abort_count !== 8'd255) begin n_err++; $display("FAIL abort_sat: got %0d want 255", abort_count); end
    tick(1, 90, 70, 1, 0, 0);
    tick(1, 90, 70, 2, 0, 1);
    tick(1, 90, 70, 1, 0, 0);
    n_vec++; if (abort_count !== 8'd0) begin n_err++; $display("FAIL clear_wins: got %0d want 0", abort_count); end
    tick(0, 0, 0, 0, 0, 0);
    n_vec++; if (abort_count !== 8'd1) begin n_err++; $display("FAIL after_clear: got %0d want 1", abort_count); end
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    fill(1, 3, FILL, 0, 0, 0);
    idle(2);
    n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL rmr_queued: got %0b want 1", ev_valid); end
    fill(0, 5, 128, 0, 0, 0);
    reset_on();
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL rmr_valid: got %0b want 0", ev_valid); end
    n_vec++; if (ev_tile !== 2'd0) begin n_err++; $display("FAIL rmr_tile: got %0d want 0", ev_tile); end
    n_vec++; if (ev_colour !== 3'd0) begin n_err++; $display("FAIL rmr_colour: got %0d want 0", ev_colour); end
    n_vec++; if (ev_lit !== 1'b0) begin n_err++; $display("FAIL rmr_lit: got %0b want 0", ev_lit); end
    reset_off();
    fill(0, 5, FILL, 0, 10, 0);
    idle(2);
    n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL rmr_event: got %0b want 1", ev_valid); end
    n_vec++; if (ev_tile !== 2'd0) begin n_err++; $display("FAIL rmr_ev_tile: got %0d want 0", ev_tile); end
    n_vec++; if (ev_colour !== 3'd5) begin n_err++; $display("FAIL rmr_ev_colour: got %0d want 5", ev_colour); end
    n_vec++; if (abort_count !== 8'd0) begin n_err++; $display("FAIL rmr_abort: got %0d want 0", abort_count); end
    pop_one();
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL rmr_one_event: got %0b want 0", ev_valid); end
  endtask

  task automatic test_random();
    int cur_t = 0;
    int cur_c = 1;
    int e;
    for (int i = 0; i < 6000; i++) begin
      bit rdy = (int'($urandom_range(99)) < 25);
      bit clr = (int'($urandom_range(999)) < 2);
      int r   = int'($urandom_range(99));
      if (int'($urandom_range(999)) < 3) begin
        cur_t = int'($urandom_range(3));
        cur_c = int'($urandom_range(7));
      end
      if (r < 15) tick(0, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(7)), rdy, clr);
      else if (r < 20) tick(1, 160 + int'($urandom_range(95)), int'($urandom_range(255)), int'($urandom_range(7)), rdy, clr);
      else tick(1, (cur_t % 2) * 80 + int'($urandom_range(79)), (cur_t / 2) * 60 + int'($urandom_range(59)), cur_c, rdy, clr);
      e = (m_q.size() > 0) ? m_q[0] : 0;
      n_vec++; if (ev_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, ev_valid, m_q.size() > 0); end
      n_vec++; if (ev_tile !== 2'(e >> 4)) begin n_err++; $display("FAIL rnd_tile@%0d: got %0d want %0d", i, ev_tile, e >> 4); end
      n_vec++; if (ev_colour !== 3'((e >> 1) & 7)) begin n_err++; $display("FAIL rnd_colour@%0d: got %0d want %0d", i, ev_colour, (e >> 1) & 7); end
      n_vec++; if (ev_lit !== 1'(e & 1)) begin n_err++; $display("FAIL rnd_lit@%0d: got %0b want %0d", i, ev_lit, e & 1); end
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow@%0d: got %0b want %0b", i, overflow, m_ovf); end
      n_vec++; if (abort_count !== 8'(m_abort)) begin n_err++; $display("FAIL rnd_abort@%0d: got %0d want %0d", i, abort_count, m_abort); end
    end
  endtask

  initial begin
    reset = 1; plot = 0; x = 0; y = 0; colour = 0; ev_ready = 0; clear_stats = 0;
    test_reset();
    test_single_fill();
    test_abort();
    test_overflow();
    test_full_push_pop();
    test_out_of_range();
    test_abort_saturate();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
